// File: rtl/pack_if.sv
// pack_if: word-stream input and packed-vector output handshake bundle for pack.
interface pack_if #(parameter int W = 8, parameter int D = 4);
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_data;
    logic           s_last;
    logic           m_valid;
    logic           m_ready;
    logic [D*W-1:0] m_data;
    logic [D-1:0]   m_keep;
    modport slave (input s_valid, s_data, s_last, m_ready, output s_ready, m_valid, m_data, m_keep);
    modport master (output s_valid, s_data, s_last, m_ready, input s_ready, m_valid, m_data, m_keep);
endinterface

// File: rtl/pack.sv
// pack: gathers D W-bit words into one D*W vector; accumulator plus output register give two vectors of slack.
module pack #(
    parameter int W = 8,
    parameter int D = 4
) (
    input logic   clk,
    input logic   rst,
    pack_if.slave bus
);
    localparam int IW = D > 1 ? $clog2(D) : 1;
    logic [IW-1:0]  idx;
    logic [D*W-1:0] lanes, nxt_lanes, m_data;
    logic [D-1:0]   acc_keep, nxt_keep, m_keep;
    logic           acc_full, m_valid, xfer, close, drain;
    assign bus.s_ready = !acc_full && !rst;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = m_data;
    assign bus.m_keep  = m_keep;
    assign xfer  = bus.s_valid && bus.s_ready;
    assign close = xfer && (idx == IW'(D - 1) || bus.s_last);
    assign drain = m_valid && bus.m_ready;
    // Lanes above idx are already zero because lanes are cleared on every close.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            nxt_lanes[i*W +: W] = (idx == IW'(i)) ? bus.s_data : lanes[i*W +: W];
            nxt_keep[i]         = IW'(i) <= idx;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            lanes    <= '0;
            acc_keep <= '0;
            acc_full <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_keep   <= '0;
        end else begin
            if (xfer)
                idx <= close ? '0 : idx + IW'(1);
            if (drain && acc_full) begin
                m_data   <= lanes;
                m_keep   <= acc_keep;
                lanes    <= '0;
                acc_full <= 1'b0;
            end else if (close && !(m_valid && !bus.m_ready)) begin
                m_data  <= nxt_lanes;
                m_keep  <= nxt_keep;
                m_valid <= 1'b1;
                lanes   <= '0;
            end else begin
                if (drain)
                    m_valid <= 1'b0;
                if (close) begin
                    lanes    <= nxt_lanes;
                    acc_keep <= nxt_keep;
                    acc_full <= 1'b1;
                end else if (xfer) begin
                    lanes <= nxt_lanes;
                end
            end
        end
    end
endmodule

// File: tb/tb_pack.sv
// tb_pack: scoreboard bench for pack (W=8, D=4); stimulus pushes expected vectors, a negedge monitor pops them.
module tb_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    pack_if #(.W(8), .D(4)) bus ();
    pack #(.W(8), .D(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pops = 0;
    logic [35:0] q[$];
    logic [31:0] last_data;
    logic [3:0]  last_keep;
    logic [31:0] mv;
    logic [3:0]  mk;
    int midx;
    logic hold;
    logic [31:0] hdata;
    logic [3:0]  hkeep;
    logic done;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // Reference model: lane midx takes the word; a close pushes the expected vector.
    task automatic model_put(input logic [7:0] d, input logic l);
        mv[midx*8 +: 8] = d;
        mk[midx] = 1'b1;
        if (midx == 3 || l) begin
            q.push_back({mv, mk});
            mv = '0;
            mk = '0;
            midx = 0;
        end else begin
            midx++;
        end
    endtask

    task automatic model_clear();
        q.delete();
        mv = '0;
        mk = '0;
        midx = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data = d;
        bus.s_last = l;
        @(negedge clk);
        while (!bus.s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.s_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got s_ready=0 want 1 for word %h", d);
        end else begin
            model_put(d, l);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
    endtask

    task automatic cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stable_valid", 64'(bus.m_valid), 64'd1);
                chk("stable_data", 64'(bus.m_data), 64'(hdata));
                chk("stable_keep", 64'(bus.m_keep), 64'(hkeep));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_vector: got %h/%b want none", bus.m_data, bus.m_keep);
                end else begin
                    logic [35:0] e;
                    e = q.pop_front();
                    chk("vec_data", 64'(bus.m_data), 64'(e[35:4]));
                    chk("vec_keep", 64'(bus.m_keep), 64'(e[3:0]));
                end
                last_data = bus.m_data;
                last_keep = bus.m_keep;
                pops++;
            end
            hold = bus.m_valid && !bus.m_ready;
            hdata = bus.m_data;
            hkeep = bus.m_keep;
        end
    end

    initial begin
        int acc;
        int p0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_last = 1'b0;
        bus.m_ready = 1'b1;
        done = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_keep", 64'(bus.m_keep), 64'd0);
        chk("rst_m_data", 64'(bus.m_data), 64'd0);
        chk("rst_s_ready_after", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;

        // basic ordering
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        chk("latency_valid", 64'(bus.m_valid), 64'd1);
        cycles(2);
        chk("basic_data", 64'(last_data), 64'h44332211);
        chk("basic_keep", 64'(last_keep), 64'hF);

        // early close, then a full vector
        send(8'hAA, 0); send(8'hBB, 1);
        chk("early_valid", 64'(bus.m_valid), 64'd1);
        cycles(2);
        chk("early_data", 64'(last_data), 64'h0000BBAA);
        chk("early_keep", 64'(last_keep), 64'h3);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        cycles(2);
        chk("after_early_data", 64'(last_data), 64'h04030201);

        // s_last on the final lane is a normal full close
        send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
        cycles(2);
        chk("last_full_data", 64'(last_data), 64'h08070605);
        chk("last_full_keep", 64'(last_keep), 64'hF);

        // backpressure: 12 offers, only 8 fit
        bus.m_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data = 8'(8'h10 + acc);
            @(negedge clk);
            if (bus.s_ready) begin
                model_put(bus.s_data, 1'b0);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd8);
        chk("bp_s_ready", 64'(bus.s_ready), 64'd0);
        chk("bp_held_data", 64'(bus.m_data), 64'h13121110);
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_v1_valid", 64'(bus.m_valid), 64'd1);
        chk("bp_v1_data", 64'(bus.m_data), 64'h13121110);
        @(negedge clk);
        chk("bp_v2_valid", 64'(bus.m_valid), 64'd1);
        chk("bp_v2_data", 64'(bus.m_data), 64'h17161514);
        @(negedge clk);
        chk("bp_drained", 64'(bus.m_valid), 64'd0);
        chk("bp_resume", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;

        // random valid/ready duty cycles with random s_last
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    send(8'(8'h50 + i), $urandom_range(0, 3) == 0);
                    cycles($urandom_range(0, 2));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.m_ready = $urandom_range(0, 2) != 0;
                end
            end
        join
        bus.m_ready = 1'b1;
        // flush any partial group so every word is accounted for
        send(8'hEE, 1);
        cycles(6);
        chk("rand_drained", 64'(q.size()), 64'd0);

        // reset mid-operation
        bus.m_ready = 1'b0;
        send(8'h20, 0); send(8'h21, 0); send(8'h22, 0); send(8'h23, 0);
        send(8'h30, 0); send(8'h31, 0); send(8'h32, 0);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        chk("midrst_s_ready", 64'(bus.s_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("midrst_m_keep", 64'(bus.m_keep), 64'd0);
        bus.m_ready = 1'b1;
        p0 = pops;
        send(8'h40, 0); send(8'h41, 0); send(8'h42, 0); send(8'h43, 0);
        cycles(4);
        chk("midrst_one_vector", 64'(pops - p0), 64'd1);
        chk("midrst_data", 64'(last_data), 64'h43424140);
        chk("midrst_keep", 64'(last_keep), 64'hF);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pack.md
Name: pack

Overview:
- Gathers D consecutive W-bit words from a valid/ready stream into one packed D×W vector.
- Lane 0 holds the first word received.
- Sits directly upstream of unpack and is its exact inverse: unpack(pack(x)) reproduces x word for word.
- Supports early termination via s_last with a lane-keep mask, and is double-buffered so the input keeps flowing while the output stalls.

Parameters:
W, 8, word width in bits (W ≥ 1)
D, 4, words per packed vector (D ≥ 1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
s_valid  input  1  input word valid
s_ready  output  1  input word accepted when s_valid && s_ready
s_data  input  W  input word
s_last  input  1  final word of a group; closes the vector early (sampled with s_data)
m_valid  output  1  packed vector valid
m_ready  input  1  consumer accepts vector when m_valid && m_ready
m_data  output  D*W  packed vector, lane i = bits [i*W +: W]
m_keep  output  D  bit i set when lane i holds a received word

Behaviour:
- Storage:
  - Accumulator: lanes plus lane index idx, range 0..D-1.
  - acc_full flag: a vector is complete but waiting for the output register.
  - Output register: m_data, m_keep, m_valid.
- Reset (rst high at a clock edge):
  - idx=0, acc_full=0, m_valid=0, m_data=0, m_keep=0.
  - Any partial or pending vector is discarded.
  - s_ready=0 while rst is high.
- Input acceptance:
  - s_ready = !acc_full && !rst.
  - On a transfer, s_data is written to lane idx and idx increments.
- Vector close: the transfer closes the vector when idx==D-1 or s_last==1.
  - Keep mask = bits 0..idx set.
  - Lanes above idx read as zero.
  - idx returns to 0.
- Routing a closed vector:
  - If the output register is empty, or drains in the same cycle (m_valid && m_ready), the vector loads directly into the output register. m_valid is high the cycle after the closing word's edge (latency 1 cycle).
  - Otherwise it stays in the accumulator with acc_full=1. s_ready drops the next cycle.
- Drain:
  - When m_valid && m_ready and acc_full=1, the accumulator moves to the output register the same edge and acc_full clears. m_valid stays high, so vectors go out back-to-back.
  - When m_valid && m_ready and nothing is pending, m_valid=0.
- Throughput:
  - One word per cycle sustained with m_ready high.
  - With m_ready held low, accepts exactly 2·D words (two full vectors), then stalls.
- Output stability: m_data and m_keep are stable while m_valid && !m_ready. m_valid never drops without a handshake.
- s_last with idx==D-1 is identical to a normal full close, keep all ones.
- D=1: every accepted word is a full vector with m_keep=1.
- s_data and s_last are ignored when s_valid is low. Invalid inputs never alter state.
- Internal lane storage is cleared on close, so zero padding is guaranteed for partial vectors.

Test Plan:
- Basic ordering: W=8, D=4; send 0x11,0x22,0x33,0x44 with m_ready=1 → one vector m_data=0x44332211, m_keep=4'b1111, m_valid one cycle after the 4th word is accepted.
- Round trip: pack output wired into unpack; 8 random groups of 4 words → unpack emits identical words in identical order, no timeout within 1e6 cycles.
- Early close: send 0xAA, then 0xBB with s_last=1 → m_data=0x0000BBAA, m_keep=4'b0011; the next 4 words form a full vector.
- Backpressure: m_ready=0, 10 words offered → exactly 8 accepted, s_ready low from then on. Raise m_ready → the two vectors emerge on consecutive cycles, then input resumes.
- Randomized valid/ready: random s_valid/m_ready duty cycles, 200 words, random s_last → scoreboard matches every vector and keep mask. m_data is stable whenever m_valid && !m_ready.
- Reset mid-operation: accept 3 words, plus one full vector stalled, then pulse rst one cycle → m_valid=0, m_keep=0, nothing stale emitted. The next 4 words produce exactly one correct vector.
